// File: rtl/mem_txn_fsm.sv
`default_nettype none
// =============================================================================
// mem_txn_fsm : breaks one flash read/write request into SPI controller bytes
// Rev 1.0
// =============================================================================
module mem_txn_fsm #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter logic [15:0] POLL_MAX   = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic        req_quad,
    input  logic [23:0] req_addr,
    input  logic [8:0]  req_len,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        spi_start,
    output logic        spi_rw,
    output logic        spi_quad,
    output logic        spi_tx_valid,
    output logic [7:0]  spi_tx_data,
    input  logic        spi_tx_ready,
    input  logic        spi_rx_valid,
    input  logic [7:0]  spi_rx_data,
    output logic        spi_rx_ready,
    input  logic        spi_done
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WREN     = 4'd1,
        S_GAP1     = 4'd2,
        S_CMD      = 4'd3,
        S_ADDR     = 4'd4,
        S_DUMMY    = 4'd5,
        S_RDATA    = 4'd6,
        S_WDATA    = 4'd7,
        S_GAP2     = 4'd8,
        S_POLL_CMD = 4'd9,
        S_POLL_RD  = 4'd10,
        S_FIN      = 4'd11
    } state_t;

    state_t        state_q, state_d;
    logic          rw_q, rw_d;
    logic          quad_q, quad_d;
    logic [23:0]   addr_q, addr_d;
    logic [8:0]    len_q, len_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   poll_q, poll_d;
    logic          sent_q, sent_d;
    logic          err_q, err_d;
    logic [7:0]    rbuf_q, rbuf_d;
    logic          rbuf_vld_q, rbuf_vld_d;

    logic          tx_state;
    logic          tx_avail;
    logic [7:0]    tx_byte;
    logic          byte_done;
    logic [16:0]   poll_inc;

    assign rd_valid  = rbuf_vld_q;
    assign rd_data   = rbuf_q;
    assign byte_done = sent_q & spi_done;
    assign poll_inc  = {1'b0, poll_q} + 17'd1;

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        quad_d       = quad_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        poll_d       = poll_q;
        sent_d       = sent_q;
        err_d        = err_q;
        rbuf_d       = rbuf_q;
        rbuf_vld_d   = rbuf_vld_q;
        req_ready    = 1'b0;
        wr_ready     = 1'b0;
        spi_start    = 1'b0;
        spi_rw       = 1'b0;
        spi_quad     = 1'b0;
        spi_tx_valid = 1'b0;
        spi_tx_data  = 8'h00;
        spi_rx_ready = 1'b0;
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_FIN);
        err          = (state_q == S_FIN) & err_q;
        tx_state     = 1'b0;
        tx_avail     = 1'b1;
        tx_byte      = 8'h00;

        if (rbuf_vld_q && rd_ready) begin
            rbuf_vld_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    rw_d   = req_rw;
                    quad_d = req_quad;
                    addr_d = req_addr;
                    len_d  = req_len;
                    cnt_d  = 9'd0;
                    gap_d  = '0;
                    poll_d = 16'd0;
                    sent_d = 1'b0;
                    err_d  = 1'b0;
                    if (req_len == 9'd0 || req_len > 9'd256) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = req_rw ? S_CMD : S_WREN;
                    end
                end
            end
            S_WREN: begin
                tx_state = 1'b1;
                tx_byte  = 8'h06;
                if (byte_done) begin
                    gap_d   = '0;
                    state_d = S_GAP1;
                end
            end
            S_GAP1, S_GAP2: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = (state_q == S_GAP1) ? S_CMD : S_POLL_CMD;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_CMD: begin
                tx_state = 1'b1;
                if (rw_q) tx_byte = quad_q ? 8'h6B : 8'h03;
                else      tx_byte = quad_q ? 8'h32 : 8'h02;
                if (byte_done) begin
                    cnt_d   = 9'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                tx_state = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    tx_byte = addr_q[23:16];
                    2'd1:    tx_byte = addr_q[15:8];
                    default: tx_byte = addr_q[7:0];
                endcase
                if (byte_done) begin
                    if (cnt_q == 9'd2) begin
                        cnt_d = 9'd0;
                        if (!rw_q)       state_d = S_WDATA;
                        else if (quad_q) state_d = S_DUMMY;
                        else             state_d = S_RDATA;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            S_DUMMY: begin
                // One zero byte yields the eight dummy clocks of the quad read
                tx_state = 1'b1;
                tx_byte  = 8'h00;
                if (byte_done) state_d = S_RDATA;
            end
            S_RDATA: begin
                spi_start    = 1'b1;
                spi_rw       = 1'b1;
                spi_quad     = quad_q;
                spi_rx_ready = ~rbuf_vld_q;
                if (spi_rx_valid && !rbuf_vld_q) begin
                    rbuf_d     = spi_rx_data;
                    rbuf_vld_d = 1'b1;
                    if (cnt_q == len_q - 9'd1) state_d = S_FIN;
                    else                       cnt_d   = cnt_q + 9'd1;
                end
            end
            S_WDATA: begin
                tx_state = 1'b1;
                tx_byte  = wr_data;
                tx_avail = wr_valid;
                spi_quad = quad_q;
                wr_ready = ~sent_q & spi_tx_ready;
                if (byte_done) begin
                    if (cnt_q == len_q - 9'd1) begin
                        gap_d   = '0;
                        state_d = S_GAP2;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            S_POLL_CMD: begin
                tx_state = 1'b1;
                tx_byte  = 8'h05;
                if (byte_done) state_d = S_POLL_RD;
            end
            S_POLL_RD: begin
                spi_start    = 1'b1;
                spi_rw       = 1'b1;
                spi_rx_ready = 1'b1;
                if (spi_rx_valid) begin
                    if (!spi_rx_data[0]) begin
                        state_d = S_FIN;
                    end else begin
                        poll_d = (poll_q == 16'hFFFF) ? poll_q : poll_inc[15:0];
                        if (poll_inc >= {1'b0, POLL_MAX}) begin
                            err_d   = 1'b1;
                            state_d = S_FIN;
                        end
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared single-byte TX handshake: present, hand off, then wait for completion
        if (tx_state) begin
            spi_start    = 1'b1;
            spi_tx_valid = ~sent_q & tx_avail;
            spi_tx_data  = sent_q ? 8'h00 : tx_byte;
            if (!sent_q && tx_avail && spi_tx_ready) sent_d = 1'b1;
            if (byte_done)                           sent_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rw_q       <= 1'b0;
            quad_q     <= 1'b0;
            addr_q     <= 24'd0;
            len_q      <= 9'd0;
            cnt_q      <= 9'd0;
            gap_q      <= '0;
            poll_q     <= 16'd0;
            sent_q     <= 1'b0;
            err_q      <= 1'b0;
            rbuf_q     <= 8'h00;
            rbuf_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            quad_q     <= quad_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            poll_q     <= poll_d;
            sent_q     <= sent_d;
            err_q      <= err_d;
            rbuf_q     <= rbuf_d;
            rbuf_vld_q <= rbuf_vld_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_txn_fsm.sv
`default_nettype none
// =============================================================================
// tb_mem_txn_fsm : directed bench with a byte-level SPI controller model
// Rev 1.0
// =============================================================================
module tb_mem_txn_fsm;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_rw, req_quad;
    logic [23:0] req_addr;
    logic [8:0]  req_len;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid, rd_ready;
    logic [7:0]  rd_data;
    logic        busy, done, err;
    logic        spi_start, spi_rw, spi_quad;
    logic        spi_tx_valid, spi_tx_ready;
    logic [7:0]  spi_tx_data;
    logic        spi_rx_valid, spi_rx_ready;
    logic [7:0]  spi_rx_data;
    logic        spi_done;

    mem_txn_fsm #(
        .GAP_CYCLES (4),
        .POLL_MAX   (16'd4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_quad     (req_quad),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .spi_start    (spi_start),
        .spi_rw       (spi_rw),
        .spi_quad     (spi_quad),
        .spi_tx_valid (spi_tx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_ready (spi_tx_ready),
        .spi_rx_valid (spi_rx_valid),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_ready (spi_rx_ready),
        .spi_done     (spi_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Controller model state and transaction logs ({quad, rw, byte} for TX)
    logic [9:0] tx_log[$];
    logic [1:0] rx_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] rxq[$];
    logic [7:0] wq[$];
    logic [9:0] exp_tx[$];
    int  done_cnt, start_cnt, gap_cnt, min_gap, low_run;
    logic err_at_done, start_at_done;
    logic pend_tx, wr_adv, wr_fire;
    int  tx_dly, rx_gap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] all_outs();
        return {req_ready, wr_ready, rd_valid, rd_data, busy, done, err, spi_start,
                spi_rw, spi_quad, spi_tx_valid, spi_tx_data, spi_rx_ready};
    endfunction

    task automatic clear_logs();
        tx_log.delete(); rx_log.delete(); rd_log.delete();
        rxq.delete(); wq.delete(); exp_tx.delete();
        done_cnt = 0; start_cnt = 0; gap_cnt = 0; min_gap = 1000;
        err_at_done = 1'b0; start_at_done = 1'b0;
    endtask

    task automatic check_tx(input string name);
        check({name, "_tx_n"}, tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            check($sformatf("%s_tx%0d", name, i), {22'd0, tx_log[i]}, {22'd0, exp_tx[i]});
    endtask

    task automatic do_req(input logic rw, input logic quad, input logic [23:0] addr,
                          input logic [8:0] len, input logic expect_start);
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_quad = quad; req_addr = addr; req_len = len;
        #2;
        check("req_ready_idle", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        check("req_ready_busy", req_ready, 1'b0);
        check("busy_after_accept", busy, 1'b1);
        if (expect_start) begin
            check("first_start", spi_start, 1'b1);
            check("first_tx_valid", spi_tx_valid, 1'b1);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        check({tag, "_done_in_time"}, (done_cnt != 0), 1'b1);
    endtask

    // Byte-level controller: TX ready always; done two cycles after handoff; RX every third cycle
    initial begin : ctrl_model
        spi_tx_ready = 1'b1; spi_rx_valid = 1'b0; spi_rx_data = 8'h00; spi_done = 1'b0;
        wr_valid = 1'b0; wr_data = 8'h00;
        pend_tx = 1'b0; wr_adv = 1'b0; tx_dly = 0; rx_gap = 0; low_run = 0;
        forever begin
            @(negedge clk); #1;
            spi_done = 1'b0; spi_rx_valid = 1'b0; wr_fire = 1'b0;
            if (!rst_n) begin
                pend_tx = 1'b0; tx_dly = 0; rx_gap = 0; wr_adv = 1'b0; low_run = 0;
            end else begin
                if (done) begin
                    done_cnt++; err_at_done = err; start_at_done = spi_start;
                end
                if (spi_start) start_cnt++;
                if (busy && !spi_start) low_run++;
                else if (spi_start && low_run > 0) begin
                    gap_cnt++;
                    if (low_run < min_gap) min_gap = low_run;
                    low_run = 0;
                end else low_run = 0;
                if (rd_valid && rd_ready) rd_log.push_back(rd_data);
                if (pend_tx) begin
                    if (tx_dly == 0) begin spi_done = 1'b1; pend_tx = 1'b0; end
                    else tx_dly--;
                end else if (spi_tx_valid) begin
                    tx_log.push_back({spi_quad, spi_rw, spi_tx_data});
                    pend_tx = 1'b1; tx_dly = 1;
                    wr_fire = wr_ready && wr_valid;
                end
                if (rx_gap > 0) rx_gap--;
                else if (spi_start && spi_rw && spi_rx_ready && rxq.size() > 0) begin
                    spi_rx_valid = 1'b1;
                    spi_rx_data  = rxq.pop_front();
                    rx_log.push_back({spi_quad, spi_rw});
                    rx_gap = 2;
                end
            end
            if (wr_adv && wq.size() > 0) void'(wq.pop_front());
            wr_adv   = wr_fire;
            wr_valid = (wq.size() > 0);
            wr_data  = wr_valid ? wq[0] : 8'h00;
        end
    end

    initial begin : main
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_quad = 1'b0;
        req_addr = 24'd0; req_len = 9'd0; rd_ready = 1'b1;
        clear_logs();

        repeat (3) @(negedge clk);
        #2;
        check("reset_outs", {5'd0, all_outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("post_reset_req_ready", req_ready, 1'b1);
        check("post_reset_busy", busy, 1'b0);

        // Single read
        clear_logs();
        rxq = '{8'hA5, 8'h5A};
        exp_tx = '{10'h003, 10'h012, 10'h034, 10'h056};
        do_req(1'b1, 1'b0, 24'h123456, 9'd2, 1'b1);
        wait_done("rd1", 500);
        repeat (3) @(negedge clk); #2;
        check_tx("rd1");
        check("rd1_rx_n", rx_log.size(), 2);
        check("rd1_rx0_mode", rx_log[0], 2'b01);
        check("rd1_rd_n", rd_log.size(), 2);
        check("rd1_rd0", rd_log[0], 8'hA5);
        check("rd1_rd1", rd_log[1], 8'h5A);
        check("rd1_done_cnt", done_cnt, 1);
        check("rd1_err", err_at_done, 1'b0);

        // Quad read with dummy byte
        clear_logs();
        rxq = '{8'hC3};
        exp_tx = '{10'h06B, 10'h000, 10'h000, 10'h010, 10'h000};
        do_req(1'b1, 1'b1, 24'h000010, 9'd1, 1'b1);
        wait_done("qrd", 500);
        repeat (3) @(negedge clk); #2;
        check_tx("qrd");
        check("qrd_rx_n", rx_log.size(), 1);
        check("qrd_rx0_mode", rx_log[0], 2'b11);
        check("qrd_rd0", rd_log[0], 8'hC3);
        check("qrd_err", err_at_done, 1'b0);

        // Write with status polling to not-busy
        clear_logs();
        wq  = '{8'h11, 8'h22, 8'h33};
        rxq = '{8'h01, 8'h01, 8'h00};
        exp_tx = '{10'h006, 10'h002, 10'h0AB, 10'h0CD, 10'h0EF,
                   10'h011, 10'h022, 10'h033, 10'h005};
        do_req(1'b0, 1'b0, 24'hABCDEF, 9'd3, 1'b1);
        wait_done("wr1", 1000);
        repeat (3) @(negedge clk); #2;
        check_tx("wr1");
        check("wr1_status_reads", rx_log.size(), 3);
        check("wr1_status_mode", rx_log[2], 2'b01);
        check("wr1_gaps", gap_cnt, 2);
        check("wr1_gap_ge4", (min_gap >= 4), 1'b1);
        check("wr1_err", err_at_done, 1'b0);
        check("wr1_done_cnt", done_cnt, 1);
        check("wr1_wq_empty", wq.size(), 0);

        // Poll timeout: status stuck busy
        clear_logs();
        wq  = '{8'h5C};
        rxq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        exp_tx = '{10'h006, 10'h002, 10'h000, 10'h040, 10'h000, 10'h05C, 10'h005};
        do_req(1'b0, 1'b0, 24'h004000, 9'd1, 1'b1);
        wait_done("pto", 1000);
        repeat (3) @(negedge clk); #2;
        check_tx("pto");
        check("pto_status_reads", rx_log.size(), 4);
        check("pto_left", rxq.size(), 4);
        check("pto_err", err_at_done, 1'b1);
        check("pto_start_at_done", start_at_done, 1'b0);

        // Client backpressure mid-read
        clear_logs();
        rxq = '{8'h10, 8'h20, 8'h30, 8'h40};
        do_req(1'b1, 1'b0, 24'h000100, 9'd4, 1'b1);
        n = 0;
        while (rd_log.size() == 0 && n < 500) begin @(negedge clk); #2; n++; end
        check("bp_first_byte", rd_log.size(), 1);
        @(negedge clk);
        rd_ready = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        check("bp_rx_ready_low", spi_rx_ready, 1'b0);
        check("bp_rd_valid", rd_valid, 1'b1);
        check("bp_rd_data_held", rd_data, 8'h20);
        check("bp_not_pulled", rxq.size(), 2);
        @(negedge clk);
        rd_ready = 1'b1;
        wait_done("bp", 500);
        repeat (3) @(negedge clk); #2;
        check("bp_rd_n", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check($sformatf("bp_rd%0d", i), rd_log[i], 8'h10 * (i + 1));

        // Illegal lengths
        clear_logs();
        do_req(1'b1, 1'b0, 24'h000000, 9'd0, 1'b0);
        wait_done("len0", 2);
        check("len0_err", err_at_done, 1'b1);
        repeat (3) @(negedge clk); #2;
        check("len0_no_start", start_cnt, 0);
        clear_logs();
        do_req(1'b0, 1'b0, 24'h000000, 9'd257, 1'b0);
        wait_done("len257", 2);
        check("len257_err", err_at_done, 1'b1);
        repeat (3) @(negedge clk); #2;
        check("len257_no_start", start_cnt, 0);
        check("len257_done_cnt", done_cnt, 1);

        // Reset while stalled in quad write data
        clear_logs();
        wq = '{8'h77};
        do_req(1'b0, 1'b1, 24'h000200, 9'd3, 1'b1);
        n = 0;
        while (tx_log.size() < 6 && n < 500) begin @(negedge clk); #2; n++; end
        check("wrst_tx_n", tx_log.size(), 6);
        check("wrst_cmd", {22'd0, tx_log[1]}, 32'h032);
        check("wrst_data", {22'd0, tx_log[5]}, 32'h277);
        repeat (4) @(negedge clk); #2;
        check("wrst_quad_in_wdata", spi_quad, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); #2;
        check("wrst_outs", {5'd0, all_outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk); #2;
        check("wrst_no_done", done_cnt, 0);
        check("wrst_req_ready", req_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
